// File: rtl/iot_monitor_pkg.sv
// Shared types, default parameters and the saturating-add helper for the
// multi-source IoT device monitor.
package iot_monitor_pkg;

  // Default configuration of the monitor.
  localparam int DEF_WIDTH     = 8;
  localparam int DEF_NUM_SRC   = 4;
  localparam int DEF_HI_THRESH = 200;
  localparam int DEF_LO_THRESH = 150;

  // Alarm FSM states.
  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    ALARM  = 1'b1
  } alarm_state_t;

  // Result of a saturating add: clipped value plus which bound was hit.
  typedef struct packed {
    logic [31:0] value;
    logic        ovf;
    logic        unf;
  } sat_result_t;

  // Adds a signed delta to an unsigned base and clips the result to
  // [0, 2^width-1]. The sum is formed in 34 signed bits so it can never
  // wrap before the bound check (callers keep width <= 31).
  function automatic sat_result_t sat_add(input logic [31:0]        base,
                                          input logic signed [31:0] delta,
                                          input int unsigned        width);
    logic signed [33:0] sum;
    logic signed [33:0] max_v;
    sat_result_t        r;
    sum     = $signed({2'b00, base}) + 34'(delta);
    max_v   = (34'sd1 <<< width) - 34'sd1;
    r.value = base;
    r.ovf   = 1'b0;
    r.unf   = 1'b0;
    if (sum > max_v) begin
      r.value = max_v[31:0];
      r.ovf   = 1'b1;
    end else if (sum < 34'sd0) begin
      r.value = '0;
      r.unf   = 1'b1;
    end else begin
      r.value = sum[31:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/iot_monitor_multi_if.sv
// Event and status bundle between the device-event front end (master) and
// the active-device monitor (slave).
interface iot_monitor_multi_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_SRC = 4
);
  logic [NUM_SRC-1:0] change;
  logic [NUM_SRC-1:0] on_off;
  logic               clear;
  logic [WIDTH-1:0]   counter_out;
  logic [WIDTH-1:0]   counter_prev;
  logic               alarm;
  logic               ovf;
  logic               unf;
  logic [WIDTH-1:0]   peak;

  modport master (
    output change, on_off, clear,
    input  counter_out, counter_prev, alarm, ovf, unf, peak
  );

  modport slave (
    input  change, on_off, clear,
    output counter_out, counter_prev, alarm, ovf, unf, peak
  );
endinterface

// File: rtl/iot_monitor_multi_event_tally.sv
// Combinational per-cycle event tally: net signed delta = #on - #off over
// all sources whose change strobe is set.
module event_tally #(
  parameter int NUM_SRC = 4,
  parameter int CW      = $clog2(NUM_SRC + 1),
  parameter int DW      = CW + 1
) (
  input  logic [NUM_SRC-1:0]   change_i,
  input  logic [NUM_SRC-1:0]   on_off_i,
  output logic signed [DW-1:0] delta_o
);

  logic [CW-1:0] inc;
  logic [CW-1:0] dec;

  // Population counts of on events and off events.
  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      inc = inc + CW'(change_i[i] & on_off_i[i]);
      dec = dec + CW'(change_i[i] & ~on_off_i[i]);
    end
  end

  assign delta_o = $signed({1'b0, inc}) - $signed({1'b0, dec});

endmodule

// File: rtl/iot_monitor_multi.sv
// Multi-source active IoT device counter with saturation, sticky
// overflow/underflow flags, hysteresis alarm and optional peak tracking.
// Optional feature macro: IOT_MONITOR_PEAK_EN (builds the peak register).
module iot_monitor_multi
  import iot_monitor_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int NUM_SRC   = DEF_NUM_SRC,
  parameter int HI_THRESH = DEF_HI_THRESH,
  parameter int LO_THRESH = DEF_LO_THRESH
) (
  input logic               clk,
  input logic               rst,
  iot_monitor_multi_if.slave bus
);

  localparam int CW    = $clog2(NUM_SRC + 1);
  localparam int DW    = CW + 1;
  localparam int SUM_W = WIDTH + CW + 1;

  localparam logic [0:0] ST_NORMAL = 1'(NORMAL);
  localparam logic [0:0] ST_ALARM  = 1'(ALARM);

  localparam logic [WIDTH-1:0] HI_VAL = WIDTH'(HI_THRESH);
  localparam logic [WIDTH-1:0] LO_VAL = WIDTH'(LO_THRESH);

  // Threshold ordering must hold, and the exact-width sum must fit the
  // 34-bit arithmetic of the saturating-add helper.
  if (!(LO_THRESH < HI_THRESH && HI_THRESH <= (2 ** WIDTH) - 1)) begin : g_bad_thresh
    $error("iot_monitor_multi: need LO_THRESH < HI_THRESH <= 2^WIDTH-1");
  end
  if (SUM_W > 34 || WIDTH > 31) begin : g_bad_width
    $error("iot_monitor_multi: WIDTH too large for saturating add");
  end

  logic signed [DW-1:0] delta;
  sat_result_t          sat_res;

  logic [WIDTH-1:0] counter_q, counter_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [0:0]       state_q, state_d;

  event_tally #(
    .NUM_SRC (NUM_SRC),
    .CW      (CW),
    .DW      (DW)
  ) u_tally (
    .change_i (bus.change),
    .on_off_i (bus.on_off),
    .delta_o  (delta)
  );

  // Counter update: net the events, saturate, track previous value and flags.
  always_comb begin
    sat_res   = sat_add(32'(counter_q), 32'(delta), WIDTH);
    counter_d = counter_q;
    prev_d    = prev_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    if (|bus.change) begin
      counter_d = WIDTH'(sat_res.value);
      prev_d    = counter_q;
      ovf_d     = ovf_q | sat_res.ovf;
      unf_d     = unf_q | sat_res.unf;
    end
  end

  // Hysteresis alarm FSM, driven by the registered count.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NORMAL: if (counter_q >= HI_VAL) state_d = ST_ALARM;
      ST_ALARM:  if (counter_q <= LO_VAL) state_d = ST_NORMAL;
      default:   state_d = ST_NORMAL;
    endcase
  end

  // State registers; clear behaves exactly like reset and drops same-cycle events.
  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      counter_q <= '0;
      prev_q    <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      state_q   <= ST_NORMAL;
    end else begin
      counter_q <= counter_d;
      prev_q    <= prev_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      state_q   <= state_d;
    end
  end

`ifdef IOT_MONITOR_PEAK_EN
  logic [WIDTH-1:0] peak_q, peak_d;

  // Running maximum of the registered count, one cycle behind it.
  always_comb begin
    peak_d = (counter_q > peak_q) ? counter_q : peak_q;
  end

  // Peak register, cleared together with the counter.
  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign bus.peak = peak_q;
`else
  assign bus.peak = '0;
`endif

  assign bus.counter_out  = counter_q;
  assign bus.counter_prev = prev_q;
  assign bus.ovf          = ovf_q;
  assign bus.unf          = unf_q;
  assign bus.alarm        = (state_q == ST_ALARM);

endmodule

// File: doc/iot_monitor_multi.md
# iot_monitor_multi

Parametrised multi-source successor to the single-input active IoT device monitor. It counts active devices reported by NUM_SRC independent change/on_off sources in the same cycle, and saturates rather than wrapping. It also raises sticky overflow/underflow flags and drives a hysteresis alarm. It sits between the device-event front end and the status/reporting logic.

## Interface

- WIDTH, 8: counter width in bits.
- NUM_SRC, 4: number of event sources per cycle.
- HI_THRESH, 200: alarm assert threshold, inclusive.
- LO_THRESH, 150: alarm release threshold, inclusive. Must satisfy LO_THRESH < HI_THRESH <= 2^WIDTH-1. Violations are an elaboration error.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- change  in  NUM_SRC  per-source event strobe.
- on_off  in  NUM_SRC  per-source direction: 1 means device on (+1), 0 means device off (-1). Ignored where change=0.
- clear  in  1  synchronous soft clear.
- counter_out  out  WIDTH  active device count.
- counter_prev  out  WIDTH  count before the most recent non-idle update.
- alarm  out  1  hysteresis alarm.
- ovf  out  1  sticky: saturated at maximum.
- unf  out  1  sticky: saturated at zero.
- peak  out  WIDTH  highest counter_out since reset or clear. Present only with the macro; tied to 0 without it.

## Operation

- Event tally:
  - inc = popcount(change & on_off)
  - dec = popcount(change & ~on_off)
  - next = counter_out + inc - dec
  - Compute next signed, with width WIDTH + $clog2(NUM_SRC+1) + 1. It must never truncate before the saturation check.
- Saturation:
  - next > 2^WIDTH-1: counter_out <= 2^WIDTH-1 and ovf <= 1.
  - next < 0: counter_out <= 0 and unf <= 1.
  - Otherwise counter_out <= next.
- Simultaneous on and off from different sources net out before saturation. For example, count=255 with inc=2, dec=2 gives 255 and leaves ovf unchanged.
- counter_prev loads the old counter_out on every cycle with change != 0, including net-zero cycles. It holds when change == 0.
- ovf and unf stay set until rst or clear.
- Alarm FSM, states NORMAL and ALARM, evaluated on the registered counter_out:
  - NORMAL -> ALARM when counter_out >= HI_THRESH.
  - ALARM -> NORMAL when counter_out <= LO_THRESH.
  - Otherwise hold.
  - alarm = (state == ALARM).
- Priority is rst > clear > event update. If clear coincides with change, the events are discarded.
- clear has the same effect as rst: all registers go to reset values.

## Timing

- Reset values:
  - counter_out = 0
  - counter_prev = 0
  - alarm = 0, state NORMAL
  - ovf = 0
  - unf = 0
  - peak = 0
- Latency:
  - counter_out, counter_prev, ovf and unf reflect change sampled at edge N from edge N onward, i.e. visible in cycle N+1.
  - alarm follows counter_out one cycle later, i.e. 2 edges after the causing event.
- peak updates one cycle after counter_out, as max(peak, counter_out).
- rst or clear asserted mid-sequence takes effect on that edge. The next event is counted from 0 on the following edge.
- No handshake: every cycle is accepted and there is no backpressure.

## Configuration

- IOT_MONITOR_PEAK_EN:
  - Defined: the peak register and comparator are built, and peak behaves as above.
  - Undefined: no peak register is built and peak is driven constant 0. All other behaviour is identical.

## Structure

- Shared package iot_monitor_pkg:
  - alarm state typedef (NORMAL, ALARM)
  - default parameter constants
  - saturating-add helper function
- One sub-module, event_tally. It is combinational and parametrised by NUM_SRC, and outputs the signed net delta inc-dec. The top holds all registers and the FSM.

## Test plan

All scenarios use WIDTH=8, NUM_SRC=4, HI=200, LO=150.

1. Reset and clear:
   - Stimulus: rst high for 5 cycles, then low. Later drive change=4'b1111 with clear=1 in the same cycle.
   - Expected: all outputs 0 after reset. The clear cycle leaves counter_out=0.
2. Multi-source tally:
   - Stimulus: from 0, change=4'b1111, on_off=4'b1011 for one cycle.
   - Expected: counter_out=2, counter_prev=0.
   - Stimulus: next cycle change=0.
   - Expected: counter_prev stays 0.
3. Overflow saturation:
   - Stimulus: ramp to 254, then change=4'b1111, on_off=4'b1111.
   - Expected: counter_out=255, ovf=1.
   - Stimulus: then one off event.
   - Expected: counter_out=254, ovf stays 1.
4. Underflow saturation:
   - Stimulus: at 1, change=4'b0111, on_off=4'b0000.
   - Expected: counter_out=0, unf=1, counter_prev=1.
5. Alarm hysteresis:
   - Rise to 200: alarm=1 one cycle later.
   - Fall to 151: alarm still 1.
   - Fall to 150: alarm=0 one cycle later.
   - Rise to 199: alarm stays 0.
6. Peak tracking (with IOT_MONITOR_PEAK_EN):
   - Stimulus: climb to 37, fall to 5.
   - Expected: peak=37. After clear, peak=0.
   - Without the macro: peak is always 0.
